// File: rtl/gpi_debounce.sv
// Debounce conditioner for asynchronous GPI pins: synchronize, sample on a prescaled tick,
// and accept a new level only after it persists for DB_COUNT consecutive ticks.
module gpi_debounce #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TICK_DIV = 100,
    parameter int unsigned DB_COUNT = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             en,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] gpi,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(DB_COUNT + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DCNT_LAST  = CW'(DB_COUNT - 1);

    logic [WIDTH-1:0]          s1_q, s2_q;
    logic [PW-1:0]             presc_q, presc_d;
    logic                      tick_c;
    logic [WIDTH-1:0][CW-1:0]  dcnt_q, dcnt_d;
    logic [WIDTH-1:0]          gpi_q, gpi_d;
    logic [WIDTH-1:0]          rise_q, rise_d;
    logic [WIDTH-1:0]          fall_q, fall_d;
    logic                      changed_q, changed_d;

    // Prescaler: held at zero while disabled so each enable restarts a full tick period.
    always_comb begin
        presc_d = '0;
        tick_c  = 1'b0;
        if (en) begin
            if (presc_q == PRESC_LAST) begin
                tick_c = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Per-bit qualification; any agreement with the stable level or disable discards progress.
    always_comb begin
        dcnt_d = dcnt_q;
        gpi_d  = gpi_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!en || (s2_q[i] == gpi_q[i])) begin
                dcnt_d[i] = '0;
            end else if (tick_c) begin
                if (dcnt_q[i] == DCNT_LAST) begin
                    dcnt_d[i] = '0;
                    gpi_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + CW'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            presc_q   <= '0;
            dcnt_q    <= '0;
            gpi_q     <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            s1_q      <= pin_in;
            s2_q      <= s1_q;
            presc_q   <= presc_d;
            dcnt_q    <= dcnt_d;
            gpi_q     <= gpi_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign gpi     = gpi_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce: directed scenarios plus random pin/enable/reset traffic,
// every cycle compared against a tick-counting reference model.
module tb_gpi_debounce;

    localparam int TD = 4;
    localparam int DB = 3;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] pin;
    logic [W-1:0] gpi, rise, fall;
    logic         changed;

    gpi_debounce #(.WIDTH(W), .TICK_DIV(TD), .DB_COUNT(DB)) dut (
        .PCLK(clk), .PRESETn(rst_n), .en(en), .pin_in(pin),
        .gpi(gpi), .rise(rise), .fall(fall), .changed(changed)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: pin delay line, enabled-cycle counter, ticks seen per pending bit.
    logic [W-1:0] m_s1, m_s2, m_gpi, m_rise, m_fall;
    logic         m_chg;
    int           m_run;
    int           m_pend [W];
    int           n_pulse_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_gpi = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
        m_run = 0;
        for (int i = 0; i < W; i++) m_pend[i] = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".gpi"},     32'(gpi),     32'(m_gpi));
        check({tag, ".rise"},    32'(rise),    32'(m_rise));
        check({tag, ".fall"},    32'(fall),    32'(m_fall));
        check({tag, ".changed"}, 32'(changed), 32'(m_chg));
    endtask

    // One clock: predict from pre-edge inputs, then compare just after the edge.
    task automatic cyc();
        logic         tk;
        logic [W-1:0] ng, nr, nf;
        tk = en && ((m_run % TD) == TD - 1);
        ng = m_gpi; nr = '0; nf = '0;
        for (int i = 0; i < W; i++) begin
            if (!en || m_s2[i] == m_gpi[i]) begin
                m_pend[i] = 0;
            end else if (tk) begin
                m_pend[i]++;
                if (m_pend[i] == DB) begin
                    ng[i] = m_s2[i];
                    nr[i] = m_s2[i];
                    nf[i] = ~m_s2[i];
                    m_pend[i] = 0;
                end
            end
        end
        m_run = en ? m_run + 1 : 0;
        m_s2  = m_s1;
        m_s1  = pin;
        @(posedge clk);
        #1;
        m_gpi = ng; m_rise = nr; m_fall = nf; m_chg = |(nr | nf);
        check_all("cyc");
        if ((rise | fall) != '0) n_pulse_cyc++;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int lat;
    logic [W-1:0] held;

    initial begin
        rst_n = 1'b0; en = 1'b0; pin = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1; en = 1'b1;

        // Idle after reset: no activity for 100 cycles.
        n_pulse_cyc = 0;
        repeat (100) cyc();
        check("idle.gpi", 32'(gpi), 32'h00);
        check("idle.pulses", 32'(n_pulse_cyc), 0);

        // Single rising pin: latency window and a single pulse.
        pin = 8'h01; lat = -1; n_pulse_cyc = 0;
        for (int t = 1; t <= 30; t++) begin
            cyc();
            if (lat < 0 && gpi[0]) begin
                lat = t;
                check("rise0.rise", 32'(rise), 32'h01);
                check("rise0.fall", 32'(fall), 32'h00);
                check("rise0.changed", 32'(changed), 1);
            end
        end
        check("rise0.lat_ok", 32'((lat >= 11) && (lat <= 14)), 1);
        check("rise0.pulses", 32'(n_pulse_cyc), 1);

        // Glitch on bit 3 shorter than qualification.
        pin = 8'h09; n_pulse_cyc = 0;
        repeat (6) cyc();
        pin = 8'h01;
        repeat (30) cyc();
        check("glitch.gpi", 32'(gpi), 32'h01);
        check("glitch.pulses", 32'(n_pulse_cyc), 0);

        // Simultaneous rise and fall on different bits.
        pin = 8'h82; lat = -1;
        for (int t = 1; t <= 30; t++) begin
            cyc();
            if (lat < 0 && changed) begin
                lat = t;
                check("multi.rise", 32'(rise), 32'h82);
                check("multi.fall", 32'(fall), 32'h01);
                check("multi.gpi", 32'(gpi), 32'h82);
            end
        end
        check("multi.seen", 32'(lat > 0), 1);

        // Disabled: gpi frozen while pins wander; re-enable accepts within 12 cycles.
        en = 1'b0; n_pulse_cyc = 0;
        for (int t = 0; t < 50; t++) begin
            pin = 8'($urandom);
            cyc();
        end
        check("dis.gpi", 32'(gpi), 32'h82);
        check("dis.pulses", 32'(n_pulse_cyc), 0);
        pin = 8'h3C;
        repeat (4) cyc();
        en = 1'b1;
        repeat (12) cyc();
        check("reen.gpi", 32'(gpi), 32'h3C);

        // Reset with a pending change: full requalification afterwards.
        pin = 8'h3D;
        for (int t = 0; t < 40 && m_pend[0] < 2; t++) cyc();
        check("pend.two_ticks", 32'(m_pend[0]), 2);
        async_reset();
        lat = -1;
        for (int t = 1; t <= 30; t++) begin
            cyc();
            if (lat < 0 && gpi[0]) lat = t;
        end
        check("rstpend.lat_ok", 32'((lat >= 10) && (lat <= 14)), 1);
        check("rstpend.gpi", 32'(gpi), 32'h3D);

        // Random traffic.
        held = pin;
        for (int t = 0; t < 4000; t++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r < 6) pin = pin ^ 8'($urandom);
            else if (r < 9) pin = pin ^ (8'h1 << $urandom_range(0, 7));
            else if (r == 10) en = ~en;
            else if (r == 11 && !en) en = 1'b1;
            if (r == 199 && $urandom_range(0, 3) == 0) async_reset();
            else cyc();
        end
        en = 1'b1;
        repeat (20) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
